// File: rtl/pm_turnoff_pkg.sv
// Shared definitions for the PCIe power-management turn-off controller:
// FSM state encoding, default parameter values and a width helper.
package pm_turnoff_pkg;

    // Turn-off handshake states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_ACK   = 2'd2,
        ST_HOLD  = 2'd3
    } pm_state_t;

    localparam int DEF_NUM_CH      = 2;
    localparam int DEF_CNT_W       = 4;
    localparam int DEF_TIMEOUT_CYC = 1024;
    localparam int DEF_TCQ         = 1;

    // Bits needed to hold values 0..value-1; never less than 1
    function automatic int clog2(input int value);
        int res;
        int v;
        res = 0;
        v   = value - 1;
        while (v > 0) begin
            res = res + 1;
            v   = v >> 1;
        end
        return (res < 1) ? 1 : res;
    endfunction

endpackage

// File: rtl/pm_turnoff_ctrl_cnt.sv
// Single-channel outstanding-completion counter. Saturates at both ends and
// records a sticky error bit when an event would wrap it. The next-count
// value is exported so the parent can see idleness without an extra cycle.
module pm_outstanding_cnt
    import pm_turnoff_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_compl,
    input  logic             compl_done,
    output logic [CNT_W-1:0] count_nxt,
    output logic             overflow_err,
    output logic             underflow_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] count;
    logic             ovf_hit;
    logic             unf_hit;

    // Next count: a simultaneous owe/send pair cancels out
    always_comb begin
        count_nxt = count;
        ovf_hit   = 1'b0;
        unf_hit   = 1'b0;
        case ({req_compl, compl_done})
            2'b10: begin
                if (count == CNT_MAX) begin
                    ovf_hit = 1'b1;
                end else begin
                    count_nxt = count + 1'b1;
                end
            end
            2'b01: begin
                if (count == '0) begin
                    unf_hit = 1'b1;
                end else begin
                    count_nxt = count - 1'b1;
                end
            end
            default: count_nxt = count;
        endcase
    end

    // Counter and sticky error flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count         <= '0;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            count <= count_nxt;
            if (ovf_hit) begin
                overflow_err <= 1'b1;
            end
            if (unf_hit) begin
                underflow_err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/pm_turnoff_ctrl.sv
// Turn-off controller: tracks outstanding completions per channel and answers
// a power-state-change request with a single ack once everything has drained,
// or after a bounded drain period (flagged as a forced ack).
module pm_turnoff_ctrl
    import pm_turnoff_pkg::*;
#(
    parameter int NUM_CH      = DEF_NUM_CH,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int TCQ         = DEF_TCQ
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] req_compl,
    input  logic [NUM_CH-1:0] compl_done,
    input  logic              cfg_power_state_change_interrupt,
    output logic              cfg_power_state_change_ack,
    output logic              req_block,
    output logic [NUM_CH-1:0] busy_vec,
    output logic              timeout_flag,
    output logic [NUM_CH-1:0] overflow_err,
    output logic [NUM_CH-1:0] underflow_err
);

    localparam int               TMR_W    = clog2(TIMEOUT_CYC);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

    // Reject configurations the timer or channel vector cannot represent
    if (NUM_CH < 1 || NUM_CH > 16 || TIMEOUT_CYC < 2 || TCQ < 0) begin : g_bad_param
        $error("pm_turnoff_ctrl: parameter out of range");
    end

    logic [CNT_W-1:0]  cnt_nxt [NUM_CH];
    logic [NUM_CH-1:0] busy_nxt;
    logic              all_idle;

    pm_state_t         state;
    pm_state_t         state_nxt;
    logic [TMR_W-1:0]  timer;
    logic [TMR_W-1:0]  timer_nxt;
    logic              tflag_set;
    logic              tflag_clr;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        pm_outstanding_cnt #(
            .CNT_W(CNT_W)
        ) u_cnt (
            .clk          (clk),
            .rst_n        (rst_n),
            .req_compl    (req_compl[g]),
            .compl_done   (compl_done[g]),
            .count_nxt    (cnt_nxt[g]),
            .overflow_err (overflow_err[g]),
            .underflow_err(underflow_err[g])
        );
        assign busy_nxt[g] = |cnt_nxt[g];
    end

    // Idleness looks at next-count values so a final done is seen immediately
    assign all_idle = ~|busy_nxt;

    // Next-state, drain timer and timeout-flag control
    always_comb begin
        state_nxt = state;
        timer_nxt = '0;
        tflag_set = 1'b0;
        tflag_clr = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cfg_power_state_change_interrupt) begin
                    tflag_clr = 1'b1;
                    state_nxt = all_idle ? ST_ACK : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!cfg_power_state_change_interrupt) begin
                    state_nxt = ST_IDLE;
                end else if (all_idle) begin
                    state_nxt = ST_ACK;
                end else if (timer == TMR_LAST) begin
                    state_nxt = ST_ACK;
                    tflag_set = 1'b1;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            ST_ACK: begin
                state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                if (!cfg_power_state_change_interrupt) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and drain timer registers; timer is zero outside DRAIN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            timer <= '0;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
        end
    end

    // Registered outputs, decoded from the next state so they align with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_power_state_change_ack <= 1'b0;
            req_block                  <= 1'b0;
            busy_vec                   <= '0;
            timeout_flag               <= 1'b0;
        end else begin
            cfg_power_state_change_ack <= (state_nxt == ST_ACK);
            req_block                  <= (state_nxt != ST_IDLE);
            busy_vec                   <= busy_nxt;
            if (tflag_set) begin
                timeout_flag <= 1'b1;
            end else if (tflag_clr) begin
                timeout_flag <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pm_turnoff_ctrl.sv
// Bench for pm_turnoff_ctrl: directed scenarios followed by random traffic,
// every cycle compared against a transaction-level reference model.
module tb_pm_turnoff_ctrl;

    localparam int NUM_CH      = 2;
    localparam int CNT_W       = 2;
    localparam int TIMEOUT_CYC = 16;
    localparam int CMAX        = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NUM_CH-1:0] req_compl = '0;
    logic [NUM_CH-1:0] compl_done = '0;
    logic              intr = 1'b0;
    logic              ack;
    logic              req_block;
    logic [NUM_CH-1:0] busy_vec;
    logic              timeout_flag;
    logic [NUM_CH-1:0] overflow_err;
    logic [NUM_CH-1:0] underflow_err;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state: plain counts plus a description of the
    // current turn-off episode (active, already answered, cycles waited)
    int m_cnt [NUM_CH];
    bit m_ovf [NUM_CH];
    bit m_unf [NUM_CH];
    bit m_ack;
    bit m_block;
    bit m_tflag;
    bit m_answered;
    int m_waited;

    always #5 clk = ~clk;

    pm_turnoff_ctrl #(
        .NUM_CH     (NUM_CH),
        .CNT_W      (CNT_W),
        .TIMEOUT_CYC(TIMEOUT_CYC),
        .TCQ        (1)
    ) dut (
        .clk                             (clk),
        .rst_n                           (rst_n),
        .req_compl                       (req_compl),
        .compl_done                      (compl_done),
        .cfg_power_state_change_interrupt(intr),
        .cfg_power_state_change_ack      (ack),
        .req_block                       (req_block),
        .busy_vec                        (busy_vec),
        .timeout_flag                    (timeout_flag),
        .overflow_err                    (overflow_err),
        .underflow_err                   (underflow_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [NUM_CH-1:0] m_vec(input int sel);
        logic [NUM_CH-1:0] v;
        for (int i = 0; i < NUM_CH; i++) begin
            case (sel)
                0:       v[i] = (m_cnt[i] != 0);
                1:       v[i] = m_ovf[i];
                default: v[i] = m_unf[i];
            endcase
        end
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_cnt[i] = 0;
            m_ovf[i] = 1'b0;
            m_unf[i] = 1'b0;
        end
        m_ack      = 1'b0;
        m_block    = 1'b0;
        m_tflag    = 1'b0;
        m_answered = 1'b0;
        m_waited   = 0;
    endtask

    // One clock of the rules: update counts, then advance the episode
    task automatic model_step(input logic [NUM_CH-1:0] rc, input logic [NUM_CH-1:0] cd, input logic irq);
        bit idle;
        bit acked_last;
        acked_last = m_ack;
        m_ack = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rc[i] && !cd[i]) begin
                if (m_cnt[i] == CMAX) m_ovf[i] = 1'b1;
                else m_cnt[i]++;
            end else if (cd[i] && !rc[i]) begin
                if (m_cnt[i] == 0) m_unf[i] = 1'b1;
                else m_cnt[i]--;
            end
        end
        idle = 1'b1;
        for (int i = 0; i < NUM_CH; i++) if (m_cnt[i] != 0) idle = 1'b0;

        if (!m_block) begin
            if (irq) begin
                m_block    = 1'b1;
                m_tflag    = 1'b0;
                m_waited   = 0;
                m_answered = idle;
                m_ack      = idle;
            end
        end else if (m_answered) begin
            if (!acked_last && !irq) m_block = 1'b0;
        end else if (!irq) begin
            m_block = 1'b0;
        end else if (idle) begin
            m_ack = 1'b1;
            m_answered = 1'b1;
        end else if (m_waited + 1 == TIMEOUT_CYC) begin
            m_ack = 1'b1;
            m_answered = 1'b1;
            m_tflag = 1'b1;
        end else begin
            m_waited++;
        end
    endtask

    task automatic compare_all();
        check_eq("ack", ack, m_ack);
        check_eq("req_block", req_block, m_block);
        check_eq("timeout_flag", timeout_flag, m_tflag);
        check_eq("busy_vec", busy_vec, m_vec(0));
        check_eq("overflow_err", overflow_err, m_vec(1));
        check_eq("underflow_err", underflow_err, m_vec(2));
    endtask

    task automatic cyc(input logic [NUM_CH-1:0] rc, input logic [NUM_CH-1:0] cd, input logic irq);
        @(negedge clk);
        req_compl  = rc;
        compl_done = cd;
        intr       = irq;
        @(posedge clk);
        model_step(rc, cd, irq);
        #1;
        compare_all();
    endtask

    // Assert reset in the middle of a low phase, release during a high phase
    task automatic reset_mid();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_eq("rst_async_outputs",
                 {ack, req_block, timeout_flag, busy_vec, overflow_err, underflow_err}, 32'd0);
        compare_all();
        @(posedge clk);
        #1;
        compare_all();
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int seen_at;
        int ack_cnt;
        logic irq_r;
        logic [NUM_CH-1:0] rc;
        logic [NUM_CH-1:0] cd;

        // Power-on reset
        #1;
        model_reset();
        compare_all();
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Idle, interrupt at cycle 10: one-cycle ack, block until release
        for (int i = 0; i < 9; i++) cyc('0, '0, 1'b0);
        cyc('0, '0, 1'b1);
        check_eq("r25_ack", ack, 1);
        check_eq("r25_block", req_block, 1);
        for (int i = 0; i < 3; i++) begin
            cyc('0, '0, 1'b1);
            check_eq("r25_ack_once", ack, 0);
            check_eq("r25_block_hold", req_block, 1);
        end
        cyc('0, '0, 1'b0);
        check_eq("r25_block_fall", req_block, 0);

        // Drain three completions, ack one cycle after the last done
        for (int i = 0; i < 3; i++) cyc(2'b01, '0, 1'b0);
        cyc('0, '0, 1'b1);
        check_eq("r26_drain_block", req_block, 1);
        for (int k = 1; k <= 12; k++) begin
            cd = (k == 5 || k == 8 || k == 12) ? 2'b01 : 2'b00;
            cyc('0, cd, 1'b1);
            check_eq("r26_ack", ack, (k == 12) ? 1 : 0);
        end
        check_eq("r26_tflag", timeout_flag, 0);
        cyc('0, '0, 1'b1);
        cyc('0, '0, 1'b0);

        // Stuck channel forces an ack after the timeout, never repeated
        cyc(2'b10, '0, 1'b0);
        cyc('0, '0, 1'b1);
        seen_at = -1;
        ack_cnt = 0;
        for (int k = 1; k <= 40; k++) begin
            cyc('0, '0, 1'b1);
            if (ack) begin
                ack_cnt++;
                if (seen_at < 0) seen_at = k;
            end
        end
        check_eq("r27_latency", seen_at, TIMEOUT_CYC);
        check_eq("r27_ack_count", ack_cnt, 1);
        check_eq("r27_tflag", timeout_flag, 1);
        cyc('0, '0, 1'b0);
        cyc('0, 2'b10, 1'b0);
        check_eq("r27_busy_clear", busy_vec, 0);

        // Saturation at max and underflow at zero
        for (int i = 0; i < 4; i++) cyc(2'b01, '0, 1'b0);
        check_eq("r28_ovf", overflow_err, 2'b01);
        cyc('0, 2'b10, 1'b0);
        check_eq("r28_unf", underflow_err, 2'b10);
        check_eq("r28_busy1", busy_vec[1], 0);
        for (int i = 0; i < 3; i++) cyc('0, 2'b01, 1'b0);
        check_eq("r28_sat_drained", busy_vec[0], 0);
        check_eq("r28_no_unf0", underflow_err[0], 0);

        // Simultaneous owe/send holds the count; abort during drain
        cyc(2'b01, '0, 1'b0);
        cyc(2'b01, '0, 1'b0);
        cyc(2'b01, 2'b01, 1'b0);
        cyc('0, 2'b01, 1'b0);
        check_eq("r29_still_busy", busy_vec[0], 1);
        cyc('0, 2'b01, 1'b0);
        check_eq("r29_drained", busy_vec[0], 0);
        check_eq("r29_no_unf0", underflow_err[0], 0);
        cyc(2'b01, '0, 1'b0);
        cyc('0, '0, 1'b1);
        for (int i = 0; i < 3; i++) cyc('0, '0, 1'b1);
        cyc('0, '0, 1'b0);
        check_eq("r29_abort_block", req_block, 0);
        check_eq("r29_abort_ack", ack, 0);
        cyc('0, 2'b01, 1'b0);

        // Reset mid-drain, then ack straight after release
        cyc(2'b01, '0, 1'b0);
        cyc(2'b01, '0, 1'b0);
        cyc('0, '0, 1'b1);
        cyc('0, '0, 1'b1);
        reset_mid();
        cyc('0, '0, 1'b1);
        check_eq("r30_ack_after_rst", ack, 1);
        cyc('0, '0, 1'b0);
        cyc('0, '0, 1'b0);

        // Random traffic with occasional asynchronous resets
        irq_r = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            rc = NUM_CH'($urandom) & NUM_CH'($urandom);
            cd = irq_r ? NUM_CH'($urandom) : (NUM_CH'($urandom) & NUM_CH'($urandom));
            if ($urandom_range(0, 19) == 0) irq_r = ~irq_r;
            if ($urandom_range(0, 299) == 0) reset_mid();
            else cyc(rc, cd, irq_r);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
